// File: rtl/hmem_ctrl.sv
// Shared line-granular memory responder for the hart memory bus.
// One transaction in flight at a time: round-robin arbitration in IDLE, a fixed read latency,
// single-cycle write acknowledge with an invalidate broadcast, and an AMO bus lock.
module hmem_ctrl #(
  parameter int unsigned N_HART = 2,
  parameter int unsigned LINE   = 128,
  parameter int unsigned DEPTH  = 1024,
  parameter logic [63:0] BASE   = 64'h8000_0000,
  parameter int unsigned RD_LAT = 4
) (
  input  logic                   h_clk,
  input  logic                   h_rst,
  input  logic [N_HART*64-1:0]   h_addr,
  input  logic [N_HART-1:0]      h_rd,
  output logic [N_HART*LINE-1:0] h_data_in,
  output logic [N_HART-1:0]      h_dv,
  input  logic [N_HART*LINE-1:0] h_data_out,
  input  logic [N_HART-1:0]      h_wr,
  output logic [N_HART-1:0]      h_wack,
  output logic [63:0]            h_inv_addr,
  output logic [N_HART-1:0]      h_inv,
  input  logic [N_HART-1:0]      h_amo_req,
  output logic [N_HART-1:0]      h_amo_ack
);

  localparam int unsigned OFF_W = $clog2(LINE / 8);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW    = (N_HART > 1) ? $clog2(N_HART) : 1;
  localparam int unsigned CW    = $clog2(RD_LAT) + 1;
  localparam logic [63:0] OFF_MASK = 64'(LINE / 8) - 64'd1;

  typedef enum logic [1:0] {StIdle, StRdWait, StWr} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     port_q, port_d;
  logic [PW-1:0]     rr_q, rr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              in_range_q, in_range_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [63:0]       line_addr_q, line_addr_d;
  logic              lock_q, lock_d;
  logic [PW-1:0]     owner_q, owner_d;

  logic [LINE-1:0]   mem [DEPTH];

  logic              amo_any;
  logic [PW-1:0]     amo_low;
  logic              lock_eff;
  logic [PW-1:0]     owner_eff;
  logic [N_HART-1:0] elig;
  logic              gnt_vld;
  logic [PW-1:0]     gnt;
  logic              gnt_wr;
  logic [63:0]       gnt_addr;
  logic [63:0]       gnt_off;
  logic [63:0]       gnt_lidx;
  logic              gnt_in_range;

  // Pick the lowest-index lock requester and restrict eligibility to the lock owner.
  // A lock being granted this cycle already masks other ports so it cannot race a grant.
  always_comb begin
    amo_any = 1'b0;
    amo_low = '0;
    for (int i = N_HART - 1; i >= 0; i--) begin
      if (h_amo_req[i]) begin
        amo_any = 1'b1;
        amo_low = PW'(i);
      end
    end
    lock_eff  = lock_q | ((state_q == StIdle) & amo_any);
    owner_eff = lock_q ? owner_q : amo_low;
    elig = h_rd | h_wr;
    for (int unsigned i = 0; i < N_HART; i++) begin
      if (lock_eff && (PW'(i) != owner_eff)) elig[i] = 1'b0;
    end
  end

  // Round-robin search from the pointer, then decode the grantee's address.
  always_comb begin
    int unsigned j;
    gnt_vld = 1'b0;
    gnt     = '0;
    for (int unsigned k = 0; k < N_HART; k++) begin
      j = (32'(rr_q) + k) % N_HART;
      if (!gnt_vld && elig[j]) begin
        gnt_vld = 1'b1;
        gnt     = PW'(j);
      end
    end
    gnt_wr       = h_wr[gnt];
    gnt_addr     = h_addr[32'(gnt) * 64 +: 64];
    gnt_off      = gnt_addr - BASE;
    gnt_lidx     = gnt_off >> OFF_W;
    gnt_in_range = (gnt_addr >= BASE) && (gnt_lidx < 64'(DEPTH));
  end

  // Next-state logic for the transaction FSM and the bus lock.
  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    rr_d        = rr_q;
    idx_d       = idx_q;
    in_range_d  = in_range_q;
    cnt_d       = cnt_q;
    line_addr_d = line_addr_q;
    lock_d      = lock_q;
    owner_d     = owner_q;

    unique case (state_q)
      StIdle: begin
        if (gnt_vld) begin
          port_d      = gnt;
          rr_d        = (gnt == PW'(N_HART - 1)) ? '0 : gnt + 1'b1;
          idx_d       = gnt_lidx[IDX_W-1:0];
          in_range_d  = gnt_in_range;
          line_addr_d = gnt_addr & ~OFF_MASK;
          // Write wins over read when a port asks for both.
          if (gnt_wr) begin
            state_d = StWr;
          end else begin
            state_d = StRdWait;
            cnt_d   = CW'(RD_LAT - 1);
          end
        end
      end
      StRdWait: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StWr:    state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (lock_q) begin
      if (!h_amo_req[owner_q]) lock_d = 1'b0;
    end else if ((state_q == StIdle) && amo_any) begin
      lock_d  = 1'b1;
      owner_d = amo_low;
    end
  end

  // Control state; reset drops any in-flight transaction and the lock.
  always_ff @(posedge h_clk or posedge h_rst) begin
    if (h_rst) begin
      state_q     <= StIdle;
      port_q      <= '0;
      rr_q        <= '0;
      idx_q       <= '0;
      in_range_q  <= 1'b0;
      cnt_q       <= '0;
      line_addr_q <= '0;
      lock_q      <= 1'b0;
      owner_q     <= '0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      rr_q        <= rr_d;
      idx_q       <= idx_d;
      in_range_q  <= in_range_d;
      cnt_q       <= cnt_d;
      line_addr_q <= line_addr_d;
      lock_q      <= lock_d;
      owner_q     <= owner_d;
    end
  end

  // Commit write data on the grant edge; storage survives reset on purpose.
  always_ff @(posedge h_clk) begin
    if (!h_rst && (state_q == StIdle) && gnt_vld && gnt_wr && gnt_in_range) begin
      mem[gnt_lidx[IDX_W-1:0]] <= h_data_out[32'(gnt) * LINE +: LINE];
    end
  end

  // Outputs are decoded from registered state so reset clears them at once.
  // Read data is taken from storage in the dv cycle so earlier writes are visible.
  always_comb begin
    h_dv       = '0;
    h_wack     = '0;
    h_inv      = '0;
    h_inv_addr = '0;
    h_data_in  = '0;
    h_amo_ack  = '0;
    if (lock_q) h_amo_ack[owner_q] = 1'b1;
    unique case (state_q)
      StRdWait: begin
        if (cnt_q == '0) begin
          h_dv[port_q] = 1'b1;
          if (in_range_q) h_data_in[32'(port_q) * LINE +: LINE] = mem[idx_q];
        end
      end
      StWr: begin
        h_wack[port_q] = 1'b1;
        if (in_range_q) begin
          h_inv         = '1;
          h_inv[port_q] = 1'b0;
          h_inv_addr    = line_addr_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hmem_ctrl.sv
// Self-checking bench for hmem_ctrl: table of single transactions plus hand-written
// sequences for reset, round-robin order, AMO locking and rd+wr on one port.
module tb_hmem_ctrl;

  localparam int NH  = 4;
  localparam int LW  = 128;
  localparam int LAT = 4;

  localparam logic [127:0] DX = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  localparam logic [127:0] DA = {16{8'hA5}};
  localparam logic [127:0] DY = 128'hdead_beef_0000_1111_2222_3333_cafe_f00d;
  localparam logic [127:0] DW = 128'h5a5a_0000_ffff_1234_8765_4321_0f0f_f0f0;
  localparam logic [127:0] DZ = {128{1'b1}};
  localparam logic [127:0] DV = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] DU = 128'h0f1e_2d3c_4b5a_6978_8796_a5b4_c3d2_e1f0;

  logic                h_clk;
  logic                h_rst;
  logic [NH*64-1:0]    h_addr;
  logic [NH-1:0]       h_rd;
  logic [NH*LW-1:0]    h_data_in;
  logic [NH-1:0]       h_dv;
  logic [NH*LW-1:0]    h_data_out;
  logic [NH-1:0]       h_wr;
  logic [NH-1:0]       h_wack;
  logic [63:0]         h_inv_addr;
  logic [NH-1:0]       h_inv;
  logic [NH-1:0]       h_amo_req;
  logic [NH-1:0]       h_amo_ack;

  hmem_ctrl #(
    .N_HART (NH),
    .LINE   (LW),
    .DEPTH  (64),
    .BASE   (64'h8000_0000),
    .RD_LAT (LAT)
  ) dut (
    .h_clk      (h_clk),
    .h_rst      (h_rst),
    .h_addr     (h_addr),
    .h_rd       (h_rd),
    .h_data_in  (h_data_in),
    .h_dv       (h_dv),
    .h_data_out (h_data_out),
    .h_wr       (h_wr),
    .h_wack     (h_wack),
    .h_inv_addr (h_inv_addr),
    .h_inv      (h_inv),
    .h_amo_req  (h_amo_req),
    .h_amo_ack  (h_amo_ack)
  );

  typedef struct {
    int           port;
    bit           wr;
    logic [63:0]  addr;
    logic [127:0] wdata;
    logic [127:0] rdata;
    logic [3:0]   inv;
    logic [63:0]  ia;
  } vec_t;

  typedef struct {
    int              port;
    bit              wr;
    logic [NH*LW-1:0] data;
    logic [3:0]      inv;
    logic [63:0]     ia;
  } exp_t;

  vec_t tbl [14];
  exp_t sbq [$];
  int   n_vec = 0;
  int   n_err = 0;

  initial h_clk = 1'b0;
  always #5 h_clk = ~h_clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void push(input int p, input bit wr, input logic [127:0] rd,
                               input logic [3:0] inv, input logic [63:0] ia);
    exp_t e;
    e.port = p;
    e.wr   = wr;
    e.data = '0;
    if (!wr) e.data[p*LW +: LW] = rd;
    e.inv  = inv;
    e.ia   = ia;
    sbq.push_back(e);
  endfunction

  // Pops one expectation per dv/wack pulse and compares it.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge h_clk);
      if (!h_rst) begin
        chk("amo_onehot", 512'($onehot0(h_amo_ack)), 512'd1);
        for (int i = 0; i < NH; i++) begin
          if (h_dv[i] || h_wack[i]) begin
            if (sbq.size() == 0) begin
              n_vec++;
              n_err++;
              $display("FAIL sb_unexpected: port %0d dv=%b wack=%b, no response expected",
                       i, h_dv[i], h_wack[i]);
            end else begin
              e = sbq.pop_front();
              chk("sb_port", 512'(i), 512'(e.port));
              chk("sb_kind_wack", 512'(h_wack[i]), 512'(e.wr));
              if (e.wr) begin
                chk("sb_inv", 512'(h_inv), 512'(e.inv));
                if (e.inv != 4'b0000) chk("sb_inv_addr", 512'(h_inv_addr), 512'(e.ia));
              end else begin
                chk("sb_rdata", 512'(h_data_in), 512'(e.data));
              end
            end
          end
        end
      end
    end
  endtask

  task automatic wait_resp(input int p, input int max, output int k, output bit ok);
    int i;
    ok = 1'b0;
    k  = 0;
    i  = 0;
    while (!ok && i < max) begin
      @(negedge h_clk);
      if (h_dv[p] || h_wack[p]) begin
        ok = 1'b1;
        k  = i;
      end
      i++;
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL resp_timeout: port %0d no dv/wack within %0d cycles", p, max);
    end
  endtask

  // Drives one request, checks grant-to-response latency, then drops the request.
  task automatic run_txn(input int p, input bit wr, input logic [63:0] addr,
                         input logic [127:0] wd, input int exp_lat, input string nm);
    int k;
    bit ok;
    @(posedge h_clk);
    #1;
    h_addr[p*64 +: 64]     = addr;
    h_data_out[p*LW +: LW] = wd;
    if (wr) h_wr[p] = 1'b1;
    else    h_rd[p] = 1'b1;
    wait_resp(p, 40, k, ok);
    if (ok) chk({nm, "_lat"}, 512'(k), 512'(exp_lat));
    @(posedge h_clk);
    #1;
    h_rd[p] = 1'b0;
    h_wr[p] = 1'b0;
  endtask

  initial begin
    int k;
    bit ok;
    int dv_seen;

    tbl[0]  = '{0, 1'b1, 64'h8000_0010, DX, 128'h0, 4'b1110, 64'h8000_0010};
    tbl[1]  = '{0, 1'b0, 64'h8000_0010, 128'h0, DX, 4'b0000, 64'h0};
    tbl[2]  = '{1, 1'b1, 64'h8000_0040, DA, 128'h0, 4'b1101, 64'h8000_0040};
    tbl[3]  = '{2, 1'b0, 64'h8000_0040, 128'h0, DA, 4'b0000, 64'h0};
    tbl[4]  = '{3, 1'b0, 64'h8000_004C, 128'h0, DA, 4'b0000, 64'h0};
    tbl[5]  = '{2, 1'b1, 64'h8000_03F7, DY, 128'h0, 4'b1011, 64'h8000_03F0};
    tbl[6]  = '{1, 1'b0, 64'h8000_03F0, 128'h0, DY, 4'b0000, 64'h0};
    tbl[7]  = '{1, 1'b1, 64'h8000_0000, DW, 128'h0, 4'b1101, 64'h8000_0000};
    tbl[8]  = '{0, 1'b0, 64'h8000_0400, 128'h0, 128'h0, 4'b0000, 64'h0};
    tbl[9]  = '{3, 1'b1, 64'h8000_0400, DZ, 128'h0, 4'b0000, 64'h0};
    tbl[10] = '{0, 1'b0, 64'h7FFF_FFFF, 128'h0, 128'h0, 4'b0000, 64'h0};
    tbl[11] = '{1, 1'b1, 64'h7FFF_FFFF, DZ, 128'h0, 4'b0000, 64'h0};
    tbl[12] = '{2, 1'b0, 64'h8000_0000, 128'h0, DW, 4'b0000, 64'h0};
    tbl[13] = '{3, 1'b0, 64'h8000_03F0, 128'h0, DY, 4'b0000, 64'h0};

    h_rst      = 1'b1;
    h_addr     = '0;
    h_rd       = '0;
    h_wr       = '0;
    h_data_out = '0;
    h_amo_req  = '0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge h_clk);
    #1;
    chk("rst_dv", 512'(h_dv), 512'd0);
    chk("rst_wack", 512'(h_wack), 512'd0);
    chk("rst_inv", 512'(h_inv), 512'd0);
    chk("rst_amo_ack", 512'(h_amo_ack), 512'd0);
    chk("rst_data_in", 512'(h_data_in), 512'd0);
    h_rst = 1'b0;
    @(negedge h_clk);
    chk("idle_dv", 512'(h_dv), 512'd0);
    chk("idle_inv_addr", 512'(h_inv_addr), 512'd0);

    // Single transactions
    for (int i = 0; i < 14; i++) begin
      push(tbl[i].port, tbl[i].wr, tbl[i].rdata, tbl[i].inv, tbl[i].ia);
      run_txn(tbl[i].port, tbl[i].wr, tbl[i].addr, tbl[i].wdata,
              tbl[i].wr ? 1 : LAT, $sformatf("vec%0d", i));
    end

    // Reset while a read is counting down, with port 0 holding the lock
    @(posedge h_clk);
    #1 h_amo_req[0] = 1'b1;
    @(negedge h_clk);
    @(negedge h_clk);
    chk("lock0_ack", 512'(h_amo_ack), 512'b0001);
    @(posedge h_clk);
    #1;
    h_addr[0 +: 64] = 64'h8000_0010;
    h_rd[0] = 1'b1;
    repeat (3) @(negedge h_clk);
    #1 h_rst = 1'b1;
    #1;
    chk("midrst_dv", 512'(h_dv), 512'd0);
    chk("midrst_wack", 512'(h_wack), 512'd0);
    chk("midrst_inv", 512'(h_inv), 512'd0);
    chk("midrst_amo_ack", 512'(h_amo_ack), 512'd0);
    h_rd      = '0;
    h_amo_req = '0;
    @(posedge h_clk);
    #1 h_rst = 1'b0;
    dv_seen = 0;
    repeat (10) begin
      @(negedge h_clk);
      if (h_dv != '0) dv_seen++;
    end
    chk("midrst_no_dv", 512'(dv_seen), 512'd0);

    // Round-robin from pointer 0; first read also shows storage survived reset
    push(0, 1'b0, DX, 4'b0, 64'h0);
    push(1, 1'b0, DA, 4'b0, 64'h0);
    push(2, 1'b0, DY, 4'b0, 64'h0);
    fork
      run_txn(0, 1'b0, 64'h8000_0010, 128'h0, LAT, "rr0_p0");
      run_txn(1, 1'b0, 64'h8000_0040, 128'h0, 2 * LAT + 1, "rr0_p1");
      run_txn(2, 1'b0, 64'h8000_03F0, 128'h0, 3 * LAT + 2, "rr0_p2");
    join
    push(0, 1'b0, DX, 4'b0, 64'h0);
    run_txn(0, 1'b0, 64'h8000_0010, 128'h0, LAT, "rr_step");
    push(1, 1'b0, DA, 4'b0, 64'h0);
    push(2, 1'b0, DY, 4'b0, 64'h0);
    push(0, 1'b0, DX, 4'b0, 64'h0);
    fork
      run_txn(0, 1'b0, 64'h8000_0010, 128'h0, 3 * LAT + 2, "rr1_p0");
      run_txn(1, 1'b0, 64'h8000_0040, 128'h0, LAT, "rr1_p1");
      run_txn(2, 1'b0, 64'h8000_03F0, 128'h0, 2 * LAT + 1, "rr1_p2");
    join

    // AMO lock requested while port 0 read is in flight
    push(0, 1'b0, DX, 4'b0, 64'h0);
    @(posedge h_clk);
    #1;
    h_addr[0 +: 64] = 64'h8000_0010;
    h_rd[0] = 1'b1;
    @(posedge h_clk);
    #1 h_amo_req[1] = 1'b1;
    wait_resp(0, 20, k, ok);
    chk("amo_no_ack_in_rd", 512'(h_amo_ack), 512'd0);
    @(posedge h_clk);
    #1 h_rd[0] = 1'b0;
    @(negedge h_clk);
    chk("amo_ack_not_yet", 512'(h_amo_ack), 512'd0);
    @(negedge h_clk);
    chk("amo_ack_rise", 512'(h_amo_ack), 512'b0010);
    @(posedge h_clk);
    #1;
    h_addr[0 +: 64] = 64'h8000_0040;
    h_rd[0] = 1'b1;
    push(1, 1'b1, 128'h0, 4'b1101, 64'h8000_0080);
    run_txn(1, 1'b1, 64'h8000_0080, DV, 1, "amo_p1_wr");
    push(1, 1'b0, DV, 4'b0, 64'h0);
    run_txn(1, 1'b0, 64'h8000_0080, 128'h0, LAT, "amo_p1_rd");
    @(posedge h_clk);
    #1 h_amo_req[1] = 1'b0;
    push(0, 1'b0, DA, 4'b0, 64'h0);
    @(negedge h_clk);
    chk("amo_ack_hold", 512'(h_amo_ack), 512'b0010);
    @(negedge h_clk);
    chk("amo_release", 512'(h_amo_ack), 512'd0);
    wait_resp(0, 20, k, ok);
    if (ok) chk("amo_stalled_rd_lat", 512'(k), 512'(LAT - 1));
    @(posedge h_clk);
    #1 h_rd[0] = 1'b0;

    // Lock handoff: release and new request in the same cycle
    @(posedge h_clk);
    #1 h_amo_req[1] = 1'b1;
    @(negedge h_clk);
    @(negedge h_clk);
    chk("ho_ack1", 512'(h_amo_ack), 512'b0010);
    @(posedge h_clk);
    #1;
    h_amo_req[1] = 1'b0;
    h_amo_req[2] = 1'b1;
    @(negedge h_clk);
    chk("ho_ack1_hold", 512'(h_amo_ack), 512'b0010);
    @(negedge h_clk);
    chk("ho_gap", 512'(h_amo_ack), 512'd0);
    @(negedge h_clk);
    chk("ho_ack2", 512'(h_amo_ack), 512'b0100);
    @(posedge h_clk);
    #1 h_amo_req[2] = 1'b0;
    @(negedge h_clk);
    chk("ho_ack2_hold", 512'(h_amo_ack), 512'b0100);
    @(negedge h_clk);
    chk("ho_ack2_drop", 512'(h_amo_ack), 512'd0);

    // rd and wr together on one port: write first, read sees the new line
    push(3, 1'b1, 128'h0, 4'b0111, 64'h8000_0050);
    push(3, 1'b0, DU, 4'b0, 64'h0);
    @(posedge h_clk);
    #1;
    h_addr[3*64 +: 64]  = 64'h8000_0050;
    h_data_out[3*LW +: LW] = DU;
    h_rd[3] = 1'b1;
    h_wr[3] = 1'b1;
    wait_resp(3, 20, k, ok);
    if (ok) begin
      chk("rdwr_wack_first", 512'({h_wack[3], h_dv[3]}), 512'b10);
      chk("rdwr_wack_lat", 512'(k), 512'd1);
    end
    @(posedge h_clk);
    #1 h_wr[3] = 1'b0;
    wait_resp(3, 20, k, ok);
    if (ok) chk("rdwr_dv_lat", 512'(k), 512'(LAT));
    @(posedge h_clk);
    #1 h_rd[3] = 1'b0;

    repeat (4) @(posedge h_clk);
    chk("sb_drained", 512'(sbq.size()), 512'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hmem_ctrl.md
Name: hmem_ctrl

Overview:
Synthesizable shared-memory responder for the hart memory bus. It replaces the single-hart behavioural bus model with an N-port line-granular memory. It provides round-robin arbitration, programmable read latency, write acknowledge, write-invalidate broadcast to the other harts, and an AMO bus-lock handshake. It sits between the hart array and on-chip line storage in multi-hart builds and testbenches.

Parameters:
N_HART, 2, number of hart ports (1..8)
LINE, 128, bus/line width in bits (power of two, >=64)
DEPTH, 1024, number of lines stored
BASE, 64'h8000_0000, byte address of line 0
RD_LAT, 4, cycles from read grant to h_dv pulse (>=1)

Ports:
h_clk  in  1  clock, all logic on rising edge
h_rst  in  1  reset, asynchronous, active-high
h_addr  in  N_HART*64  per-port byte address, slice i = [64*i +: 64]
h_rd  in  N_HART  read request, held until h_dv[i]
h_data_in  out  N_HART*LINE  read data to port i, valid only with h_dv[i]
h_dv  out  N_HART  one-cycle read-data-valid pulse
h_data_out  in  N_HART*LINE  write data from port i
h_wr  in  N_HART  write request, held until h_wack[i]
h_wack  out  N_HART  one-cycle write-commit pulse
h_inv_addr  out  64  line address being invalidated (line-aligned)
h_inv  out  N_HART  one-cycle invalidate pulse per port
h_amo_req  in  N_HART  bus-lock request, level
h_amo_ack  out  N_HART  bus-lock granted, level

Behaviour:
- Reset: all outputs 0. State goes to IDLE, RR pointer to 0, lock cleared. Any in-flight read/write is dropped with no dv/wack. Storage contents are NOT cleared. Reset mid-operation takes effect immediately.
- Index: (addr-BASE) >> log2(LINE/8); low offset bits ignored. Out of range (addr<BASE or index>=DEPTH): read returns all-zero data with normal dv timing; write is dropped but still acknowledged; no invalidate is issued.
- Arbitration, in IDLE only: eligible ports are those with h_rd|h_wr. If a lock is held, only the lock owner is eligible. Round-robin search starts at the RR pointer. On grant, the pointer becomes grantee+1 mod N_HART. If a port asserts both rd and wr, the write is served first.
- FSM:
  IDLE -> RD_WAIT on read grant (latch port, index, counter=RD_LAT-1); IDLE -> WR on write grant.
  RD_WAIT: decrement counter; at 0, drive data and h_dv[p]=1 for exactly one cycle, then IDLE. Grant-to-dv latency = RD_LAT cycles. Data is sampled from storage in the dv cycle, so it reflects all earlier writes.
  WR: commit the line at the grant edge and pulse h_wack[p] in the following cycle. In the same cycle, h_inv[j]=1 for every j!=p and h_inv_addr = line-aligned address. Then IDLE.
- Throughput: at most one transaction in flight. Back-to-back grants are possible on the cycle after dv/wack.
- Requester rule: a request deasserted before dv/wack is a protocol violation, and the controller completes anyway. h_data_in slices of non-responding ports are 0.
- AMO lock: the lock is granted to the lowest-index requester with h_amo_req when no lock is held and the FSM is IDLE. h_amo_ack[i] rises the next cycle and stays high while h_amo_req[i] is high. Deassertion drops ack and releases the lock the next cycle. A release on the same cycle as a new request means the new requester is granted one cycle after release. Other ports' rd/wr stall (no grant) while locked.
- h_amo_ack is never asserted for two ports simultaneously.

Test Plan:
- Reset/idle: h_rst=1 mid-RD_WAIT -> h_dv, h_wack, h_inv, h_amo_ack all 0 immediately; after release, no dv for the dropped read; storage preserved.
- Single read, RD_LAT=4: port0 rd addr 8000_0010 preloaded line X -> h_dv[0] exactly 4 cycles after grant, for 1 cycle, data X.
- Write+invalidate, N_HART=4: port1 writes 0xA5..A5 to 8000_0040 -> h_wack[1] 1 cycle; h_inv=4'b1101, h_inv_addr=8000_0040 same cycle; subsequent port2 read returns 0xA5..A5.
- Round-robin: ports 0,1,2 all hold rd from the same cycle -> grants in order 0,1,2 with dvs spaced RD_LAT+1 cycles; repeat after pointer=1 -> order 1,2,0.
- AMO lock: port1 amo_req while port0 rd pending -> after port0 dv, ack[1]=1; port0 second rd stalls until port1 drops req; port1 rd/wr served during lock.
- Boundaries: read at BASE+DEPTH*LINE/8 -> data 0, dv normal; write there -> wack, no h_inv; read/write at BASE-1 -> same; simultaneous rd+wr on one port -> wack before dv.
